// File: rtl/tl_async_crossing_arbiter.sv
// tl_async_crossing_arbiter: shares one TLAsyncCrossingSource A/D port pair
// between NUM_REQ TileLink-UL requesters on the source clock.
//   A: round-robin grant over req_a_*; the winner is forwarded combinationally
//      to out_a_*. Each accepted beat pushes its requester ID into a FIFO.
//   D: the crossing answers in order, so the FIFO head ID steers in_d_* to
//      one req_d_valid bit; D fields are broadcast to every requester.
//   outstanding    : beats in flight (FIFO occupancy)
//   spurious_d_err : sticky, D beat seen with nothing outstanding
//   timeout_err    : sticky watchdog, built only with TL_ASYNC_ARB_TIMEOUT_EN
// Clock/reset: clock, synchronous active-high reset.
module tl_async_crossing_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_a_valid,
    output logic [NUM_REQ-1:0]    req_a_ready,
    input  logic [3*NUM_REQ-1:0]  req_a_opcode,
    input  logic [9*NUM_REQ-1:0]  req_a_address,
    input  logic [32*NUM_REQ-1:0] req_a_data,
    output logic                  out_a_valid,
    input  logic                  out_a_ready,
    output logic [2:0]            out_a_opcode,
    output logic [8:0]            out_a_address,
    output logic [31:0]           out_a_data,
    input  logic                  in_d_valid,
    output logic                  in_d_ready,
    input  logic [2:0]            in_d_opcode,
    input  logic [1:0]            in_d_param,
    input  logic [1:0]            in_d_size,
    input  logic                  in_d_denied,
    input  logic [31:0]           in_d_data,
    input  logic                  in_d_corrupt,
    output logic [NUM_REQ-1:0]    req_d_valid,
    input  logic [NUM_REQ-1:0]    req_d_ready,
    output logic [2:0]            req_d_opcode,
    output logic [1:0]            req_d_param,
    output logic [1:0]            req_d_size,
    output logic                  req_d_denied,
    output logic [31:0]           req_d_data,
    output logic                  req_d_corrupt,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                  spurious_d_err,
    output logic                  timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_OUTSTANDING < 2 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("tl_async_crossing_arbiter: illegal parameters");
    end

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic          any_req;
    logic          full;
    logic          busy;
    logic          a_fire;
    logic          d_fire;
    logic [IW-1:0] head;
    logic [IW-1:0] fifo [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    int            gi;

    // Scan downward so the smallest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = rr_ptr;
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_a_valid[idx]) begin
                grant   = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // Full uses the registered count: a same-cycle pop frees no slot.
    assign full          = (outstanding == CW'(MAX_OUTSTANDING));
    assign gi            = int'(grant);
    assign out_a_valid   = any_req & ~full;
    assign out_a_opcode  = req_a_opcode[gi*3 +: 3];
    assign out_a_address = req_a_address[gi*9 +: 9];
    assign out_a_data    = req_a_data[gi*32 +: 32];
    assign req_a_ready   = (any_req & out_a_ready & ~full)
                         ? (NUM_REQ'(1) << grant) : '0;
    assign a_fire        = out_a_valid & out_a_ready;

    assign busy        = (outstanding != '0);
    assign head        = fifo[rd_ptr];
    assign req_d_valid = busy ? (NUM_REQ'(in_d_valid) << head) : '0;
    // With nothing in flight the D channel is drained so it cannot wedge.
    assign in_d_ready  = busy ? req_d_ready[head] : 1'b1;
    assign d_fire      = busy & in_d_valid & req_d_ready[head];

    assign req_d_opcode  = in_d_opcode;
    assign req_d_param   = in_d_param;
    assign req_d_size    = in_d_size;
    assign req_d_denied  = in_d_denied;
    assign req_d_data    = in_d_data;
    assign req_d_corrupt = in_d_corrupt;

    always_ff @(posedge clock) begin
        if (a_fire) fifo[wr_ptr] <= grant;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            outstanding    <= '0;
            spurious_d_err <= 1'b0;
        end else begin
            if (a_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (d_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({a_fire, d_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (in_d_valid & ~busy) spurious_d_err <= 1'b1;
        end
    end

`ifdef TL_ASYNC_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wdog;
    logic          timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (d_fire || !busy) wdog <= '0;
            else if (wdog != WDOG_MAX) wdog <= wdog + 1'b1;
            if (wdog == WDOG_MAX) timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
